// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-memory front end.
package mem_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int MEM_OP_SIZE = 4 + ADDR_WIDTH + DATA_WIDTH;

   // One memory operation as it travels on request and response buses.
   typedef struct packed {
      logic [3:0]            byte_en;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } mem_req_t;

   // Identity of the client that issued a request; stored in the tag FIFO.
   typedef enum logic {
      CLIENT_IMEM = 1'b0,
      CLIENT_DMEM = 1'b1
   } client_id_t;

   // The client that is not `c`; used to hand the round-robin turn over.
   function automatic client_id_t other_client(input client_id_t c);
      return (c == CLIENT_IMEM) ? CLIENT_DMEM : CLIENT_IMEM;
   endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order FIFO of client tags for requests outstanding at the memory.
// Push and pop may happen together at any fill level, including full.
module mem_tag_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   // A depth of one still needs a one-bit pointer that simply stays at 0.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // Next-state: write at the tail, read from the head, track occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset flushes every outstanding tag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Protocol checks: no pop from an empty FIFO, no push into a full one
   // unless a pop frees the slot in the same cycle.
   a_no_underflow : assert property (@(posedge CLK) disable iff (RST) !(pop && empty));
   a_no_overflow  : assert property (@(posedge CLK) disable iff (RST) !(push && full && !pop));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-client front end for the single-port unified memory: round-robin
// merges imem/dmem requests, remembers who issued each one, and steers
// every in-order memory response back to its issuer.
//
// Handshake: a transfer happens on a cycle where valid and ready are both 1.
// Request side is purely combinational. mem_get_valid depends only on the
// tag FIFO head and the head client's resp_ready, never on any req_valid or
// on mem_put_ready, so the memory may derive mem_put_ready from it freely.
// While RST is high every valid/ready output is forced to 0.
module mem_port_arbiter #(
   parameter int TAG_DEPTH  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             imem_req_valid,
   output logic                             imem_req_ready,
   input  logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] imem_req,
   output logic                             imem_resp_valid,
   input  logic                             imem_resp_ready,
   output logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] imem_resp,
   input  logic                             dmem_req_valid,
   output logic                             dmem_req_ready,
   input  logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] dmem_req,
   output logic                             dmem_resp_valid,
   input  logic                             dmem_resp_ready,
   output logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] dmem_resp,
   output logic                             mem_put_valid,
   input  logic                             mem_put_ready,
   output logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] mem_put_request,
   output logic                             mem_get_valid,
   input  logic                             mem_get_ready,
   input  logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] mem_get_response
);

   import mem_pkg::*;

   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

   client_id_t       rr_ptr_q, rr_ptr_d;
   client_id_t       winner;
   client_id_t       head;
   logic             any_req;
   logic             can_issue;
   logic             put_valid;
   logic             fire;
   logic             get_valid;
   logic             pop;
   logic [0:0]       tag_din;
   logic [0:0]       tag_dout;
   logic [CNT_W-1:0] tag_count;
   logic             tag_full;
   logic             tag_empty;

   mem_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .WIDTH (1)
   ) u_tag_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (fire),
      .pop   (pop),
      .din   (tag_din),
      .dout  (tag_dout),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   // Response routing: only the head client may see a response.
   always_comb begin
      head      = client_id_t'(tag_dout);
      get_valid = !RST && !tag_empty &&
                  ((head == CLIENT_DMEM) ? dmem_resp_ready : imem_resp_ready);
      pop       = get_valid && mem_get_ready;
   end

   // Request arbitration: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      winner = CLIENT_IMEM;
      if (imem_req_valid && dmem_req_valid) begin
         winner = rr_ptr_q;
      end else if (dmem_req_valid) begin
         winner = CLIENT_DMEM;
      end
      any_req   = imem_req_valid || dmem_req_valid;
      // A pop in this cycle frees a slot, so a full FIFO can still accept.
      can_issue = !tag_full || pop;
      put_valid = !RST && can_issue && any_req;
      fire      = put_valid && mem_put_ready;
      tag_din   = winner;
      rr_ptr_d  = fire ? other_client(winner) : rr_ptr_q;
   end

   // Output drive for both directions.
   always_comb begin
      mem_put_valid   = put_valid;
      mem_put_request = (winner == CLIENT_DMEM) ? dmem_req : imem_req;
      imem_req_ready  = fire && (winner == CLIENT_IMEM);
      dmem_req_ready  = fire && (winner == CLIENT_DMEM);
      mem_get_valid   = get_valid;
      imem_resp_valid = !RST && !tag_empty && mem_get_ready && (head == CLIENT_IMEM);
      dmem_resp_valid = !RST && !tag_empty && mem_get_ready && (head == CLIENT_DMEM);
      imem_resp       = mem_get_response;
      dmem_resp       = mem_get_response;
   end

   // Round-robin pointer: after each grant the other client gets priority.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr_q <= CLIENT_IMEM;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Occupancy can never exceed the number of tag slots.
   a_count_bound : assert property (@(posedge CLK) disable iff (RST)
                                    tag_count <= CNT_W'(TAG_DEPTH));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the arbiter.
module tb_mem_port_arbiter;
   import mem_pkg::*;

   localparam int DEPTH = 2;
   localparam int W     = MEM_OP_SIZE;

   logic         CLK;
   logic         RST;
   logic         imem_req_valid, imem_req_ready;
   logic [W-1:0] imem_req;
   logic         imem_resp_valid, imem_resp_ready;
   logic [W-1:0] imem_resp;
   logic         dmem_req_valid, dmem_req_ready;
   logic [W-1:0] dmem_req;
   logic         dmem_resp_valid, dmem_resp_ready;
   logic [W-1:0] dmem_resp;
   logic         mem_put_valid, mem_put_ready;
   logic [W-1:0] mem_put_request;
   logic         mem_get_valid, mem_get_ready;
   logic [W-1:0] mem_get_response;

   mem_port_arbiter #(
      .TAG_DEPTH  (DEPTH),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req         (imem_req),
      .imem_resp_valid  (imem_resp_valid),
      .imem_resp_ready  (imem_resp_ready),
      .imem_resp        (imem_resp),
      .dmem_req_valid   (dmem_req_valid),
      .dmem_req_ready   (dmem_req_ready),
      .dmem_req         (dmem_req),
      .dmem_resp_valid  (dmem_resp_valid),
      .dmem_resp_ready  (dmem_resp_ready),
      .dmem_resp        (dmem_resp),
      .mem_put_valid    (mem_put_valid),
      .mem_put_ready    (mem_put_ready),
      .mem_put_request  (mem_put_request),
      .mem_get_valid    (mem_get_valid),
      .mem_get_ready    (mem_get_ready),
      .mem_get_response (mem_get_response)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard / model state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [0:0] exp_q[$];     // issuer ids of outstanding requests, oldest first
   bit         rr;           // client with priority on a tie (0=imem)
   bit         e_fire, e_pop, e_winner;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", name, act, exp);
      end
   endtask

   // Let inputs settle, derive what the outputs must be, and compare.
   task automatic settle_and_check();
      bit n_pos, head, e_gv, e_irv, e_drv, can, e_pv;
      #1;
      n_pos = (exp_q.size() > 0);
      head  = n_pos ? exp_q[0] : 1'b0;
      if (RST) begin
         e_gv = 0; e_irv = 0; e_drv = 0; e_pv = 0; e_pop = 0; e_fire = 0; e_winner = 0;
      end else begin
         e_gv  = n_pos && (head ? dmem_resp_ready : imem_resp_ready);
         e_pop = e_gv && mem_get_ready;
         e_irv = n_pos && mem_get_ready && !head;
         e_drv = n_pos && mem_get_ready && head;
         can   = (exp_q.size() < DEPTH) || e_pop;
         if (imem_req_valid && dmem_req_valid) e_winner = rr;
         else                                  e_winner = dmem_req_valid;
         e_pv   = can && (imem_req_valid || dmem_req_valid);
         e_fire = e_pv && mem_put_ready;
      end
      chk1("imem_req_ready", imem_req_ready, e_fire && !e_winner);
      chk1("dmem_req_ready", dmem_req_ready, e_fire && e_winner);
      chk1("mem_put_valid", mem_put_valid, e_pv);
      if (e_pv) chk("mem_put_request", mem_put_request, e_winner ? dmem_req : imem_req);
      chk1("mem_get_valid", mem_get_valid, e_gv);
      chk1("imem_resp_valid", imem_resp_valid, e_irv);
      chk1("dmem_resp_valid", dmem_resp_valid, e_drv);
      chk("imem_resp", imem_resp, mem_get_response);
      chk("dmem_resp", dmem_resp, mem_get_response);
      if (!RST) chk("count", W'(dut.tag_count), W'(exp_q.size()));
   endtask

   // Clock edge: retire the head on pop, enqueue the winner on fire.
   task automatic advance();
      @(posedge CLK);
      if (!RST) begin
         if (e_pop) void'(exp_q.pop_front());
         if (e_fire) begin
            exp_q.push_back(e_winner);
            rr = !e_winner;
         end
      end
      @(negedge CLK);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      imem_req_valid   = 0; imem_req = '0; imem_resp_ready = 1;
      dmem_req_valid   = 0; dmem_req = '0; dmem_resp_ready = 1;
      mem_put_ready    = 1; mem_get_ready = 0; mem_get_response = '0;
   endtask

   task automatic do_reset();
      RST = 1;
      exp_q.delete();
      rr = 0;
      settle_and_check();
      advance();
      RST = 0;
   endtask

   task automatic drive_random();
      imem_req_valid   = ($urandom_range(0, 9) < 7);
      dmem_req_valid   = ($urandom_range(0, 9) < 7);
      imem_req         = {$urandom(), $urandom(), $urandom()};
      dmem_req         = {$urandom(), $urandom(), $urandom()};
      imem_resp_ready  = ($urandom_range(0, 3) != 0);
      dmem_resp_ready  = ($urandom_range(0, 3) != 0);
      mem_put_ready    = ($urandom_range(0, 3) != 0);
      mem_get_ready    = ($urandom_range(0, 3) != 0);
      mem_get_response = {$urandom(), $urandom(), $urandom()};
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RST = 1;
      set_idle();
      @(negedge CLK);
      do_reset();

      // Single imem load
      imem_req_valid = 1;
      imem_req = {4'h0, 32'h0000_0100, 32'h0};
      settle_and_check();
      chk1("t1_imem_req_ready", imem_req_ready, 1'b1);
      chk("t1_put_request", mem_put_request, {4'h0, 32'h0000_0100, 32'h0});
      advance();
      imem_req_valid = 0;
      mem_get_ready = 1;
      mem_get_response = {4'h0, 32'h0000_0100, 32'hDEAD_BEEF};
      settle_and_check();
      chk1("t1_imem_resp_valid", imem_resp_valid, 1'b1);
      chk("t1_imem_resp_data", W'(imem_resp[31:0]), W'(32'hDEAD_BEEF));
      chk1("t1_dmem_resp_valid", dmem_resp_valid, 1'b0);
      advance();
      mem_get_ready = 0;
      settle_and_check();
      chk("t1_count", W'(dut.tag_count), '0);
      advance();

      // Simultaneous requests from reset alternate imem, dmem, ...
      do_reset();
      imem_req_valid = 1; imem_req = {4'h1, 32'hAAAA_0000, 32'h1111_1111};
      dmem_req_valid = 1; dmem_req = {4'h2, 32'hBBBB_0000, 32'h2222_2222};
      mem_get_ready = 1;
      for (int i = 0; i < 4; i++) begin
         mem_get_response = {$urandom(), $urandom(), $urandom()};
         settle_and_check();
         chk1("t2_imem_grant", imem_req_ready, (i % 2) == 0);
         chk1("t2_dmem_grant", dmem_req_ready, (i % 2) == 1);
         chk1("t2_imem_resp", imem_resp_valid, (i == 1) || (i == 3));
         chk1("t2_dmem_resp", dmem_resp_valid, i == 2);
         advance();
      end

      // Head backpressure: dmem then imem outstanding, dmem not consuming
      do_reset();
      set_idle();
      dmem_req_valid = 1; dmem_req = {4'h3, 32'h0000_0200, 32'h0};
      settle_and_check();
      advance();
      dmem_req_valid = 0;
      imem_req_valid = 1; imem_req = {4'h0, 32'h0000_0300, 32'h0};
      settle_and_check();
      advance();
      dmem_resp_ready = 0;
      mem_get_ready = 1;
      for (int i = 0; i < 5; i++) begin
         mem_get_response = {$urandom(), $urandom(), $urandom()};
         settle_and_check();
         chk1("t3_get_valid", mem_get_valid, 1'b0);
         chk1("t3_imem_resp", imem_resp_valid, 1'b0);
         chk1("t3_req_stall", imem_req_ready, 1'b0);
         chk("t3_count", W'(dut.tag_count), W'(2));
         advance();
      end

      // Full FIFO with push and pop together for 8 cycles
      dmem_resp_ready = 1;
      for (int i = 0; i < 8; i++) begin
         mem_get_response = {$urandom(), $urandom(), $urandom()};
         settle_and_check();
         chk1("t4_imem_req_ready", imem_req_ready, 1'b1);
         chk1("t4_get_valid", mem_get_valid, 1'b1);
         chk1("t4_route_dmem", dmem_resp_valid, i == 0);
         chk("t4_count", W'(dut.tag_count), W'(2));
         advance();
      end

      // Store passthrough to dmem
      set_idle();
      do_reset();
      dmem_req_valid = 1; dmem_req = {4'hF, 32'h0000_0040, 32'h1234_5678};
      settle_and_check();
      chk("t5_put_request", mem_put_request, {4'hF, 32'h0000_0040, 32'h1234_5678});
      chk1("t5_dmem_req_ready", dmem_req_ready, 1'b1);
      advance();
      dmem_req_valid = 0;
      mem_get_ready = 1;
      mem_get_response = {4'hF, 32'h0000_0040, 32'hCAFE_0000};
      settle_and_check();
      chk1("t5_dmem_resp_valid", dmem_resp_valid, 1'b1);
      chk1("t5_imem_resp_valid", imem_resp_valid, 1'b0);
      chk("t5_byte_en", W'(dmem_resp[W-1 -: 4]), W'(4'hF));
      advance();

      // Reset mid-operation with two requests outstanding
      set_idle();
      imem_req_valid = 1;
      settle_and_check();
      advance();
      imem_req_valid = 0; dmem_req_valid = 1;
      settle_and_check();
      advance();
      imem_req_valid = 1; dmem_req_valid = 1; mem_get_ready = 1;
      settle_and_check();
      chk1("t6_pre_get_valid", mem_get_valid, 1'b1);
      #1;
      RST = 1;
      exp_q.delete();
      rr = 0;
      settle_and_check();
      chk1("t6_rst_put_valid", mem_put_valid, 1'b0);
      chk1("t6_rst_get_valid", mem_get_valid, 1'b0);
      chk1("t6_rst_imem_ready", imem_req_ready, 1'b0);
      chk1("t6_rst_imem_resp", imem_resp_valid, 1'b0);
      chk1("t6_rst_dmem_resp", dmem_resp_valid, 1'b0);
      advance();
      RST = 0;
      mem_get_ready = 0;
      settle_and_check();
      chk("t6_count_after", W'(dut.tag_count), '0);
      chk1("t6_first_imem", imem_req_ready, 1'b1);
      chk1("t6_first_dmem", dmem_req_ready, 1'b0);
      advance();

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive_random();
         settle_and_check();
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-client front end for the single-port unified memory.
- Merges instruction-fetch (imem) and load/store (dmem) request streams onto the memory put interface.
- Records the issuing client of each accepted request in an in-order tag FIFO.
- Routes each memory response back to the client that issued it.

Parameters:
- TAG_DEPTH, 2, maximum requests outstanding at the memory (power of two, ≥1).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, request data width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset, asynchronous, active-high.
- imem_req_valid  input  1  imem request present.
- imem_req_ready  output  1  imem request accepted this cycle.
- imem_req  input  68  {byte_en[3:0], addr[31:0], data[31:0]}.
- imem_resp_valid  output  1  imem response present.
- imem_resp_ready  input  1  imem consumes response.
- imem_resp  output  68  response, same packing as imem_req.
- dmem_req_valid, dmem_req_ready, dmem_req, dmem_resp_valid, dmem_resp_ready, dmem_resp  same as imem_*.
- mem_put_valid  output  1  request to memory.
- mem_put_ready  input  1  memory accepts request.
- mem_put_request  output  68  forwarded request.
- mem_get_valid  output  1  arbiter consumes memory response this cycle.
- mem_get_ready  input  1  memory response available.
- mem_get_response  input  68  memory response.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset state: tag FIFO empty (count 0); round-robin pointer = imem.
- Outputs during reset: while RST=1 every valid/ready output is 0.
- Request side:
  - can_issue = (count < TAG_DEPTH) || pop.
  - A client is eligible when its req_valid=1.
  - Grant:
    - If only one client is eligible, it wins.
    - If both are eligible, the client indicated by the pointer wins.
  - mem_put_valid = can_issue && any eligible.
  - mem_put_request = winner's req.
  - Winner's req_ready = mem_put_valid && mem_put_ready. Loser's req_ready = 0.
  - On fire (mem_put_valid && mem_put_ready):
    - push winner id (0=imem, 1=dmem) into the tag FIFO;
    - set the pointer to the other client.
    - The pointer is unchanged when there is no fire.
- Response side:
  - head = tag FIFO head id.
  - mem_get_valid = (count > 0) && resp_ready of client[head].
  - client[head] resp_valid = (count > 0) && mem_get_ready. The other client's resp_valid = 0.
  - Both resp buses carry mem_get_response unchanged.
  - pop = mem_get_valid && mem_get_ready; advances the head.
- Path constraints:
  - The request path is combinational (zero-cycle latency).
  - mem_put_ready may depend combinationally on mem_get_valid.
  - mem_get_valid must not depend on any req_valid or on mem_put_ready, to avoid a loop.
- Simultaneous push and pop:
  - Allowed at any count, including full.
  - Count is unchanged; read/write pointers both advance.
  - When empty, a push and a pop in the same cycle cannot both occur (pop requires count>0).
- Wrap-around: read/write pointers are log2(TAG_DEPTH) bits and wrap modulo TAG_DEPTH. Count is log2(TAG_DEPTH)+1 bits.
- Backpressure:
  - resp_ready=0 at the head client stalls all responses, in order.
  - Once count==TAG_DEPTH, further requests stall until a pop.
- Starvation bound: a continuously valid client is granted within 2 fires.
- Reset mid-operation:
  - FIFO flushes immediately; pending responses are dropped.
  - The memory is reset by the same system reset, so no stale response arrives.
- Error check (simulation only): assertion fires on pop with count==0, or push when full without pop.

Decomposition:
- Package mem_pkg:
  - ADDR_WIDTH, DATA_WIDTH, MEM_OP_SIZE (=4+ADDR+DATA) constants;
  - mem_req_t packed struct {byte_en, addr, data};
  - client_id_t enum {CLIENT_IMEM=0, CLIENT_DMEM=1}.
- Sub-module mem_tag_fifo (parameter DEPTH, WIDTH=1):
  - ports push/pop/din/dout/count/full/empty;
  - same CLK and asynchronous active-high RST.
- Arbitration and routing logic stays in the top module.

Test Plan:
1. Single imem load: imem_req={0,0x0000_0100,0}, memory returns data 0xDEADBEEF next cycle → imem_req_ready=1 in the request cycle; imem_resp_valid=1 with data 0xDEADBEEF; dmem_resp_valid stays 0; count returns to 0.
2. Simultaneous requests from reset: both clients valid every cycle, all readies 1 → grant order imem, dmem, imem, dmem; responses delivered to the matching client in the same order.
3. Head backpressure: issue dmem then imem with TAG_DEPTH=2; hold dmem_resp_ready=0 for 5 cycles → mem_get_valid=0 for those 5 cycles; imem response not delivered; count=2; no new request accepted until dmem drains.
4. Full with simultaneous push/pop: count=2, dmem_resp_ready=1, new imem_req_valid=1 → pop and push in the same cycle; count stays 2; pointers wrap correctly over 8 consecutive cycles.
5. Store passthrough: dmem_req={4'b1111, 0x0000_0040, 0x12345678} → mem_put_request bit-identical; response routed to dmem with byte_en 4'b1111.
6. Reset mid-operation: assert RST asynchronously (off clock edge) with count=2 → all valid/ready outputs drop to 0 immediately; after release count=0, pointer=imem; first simultaneous request grants imem.
